// File: rtl/pifo_mon_pkg.sv
// Shared types and constants for the PIFO pop-side monitor.
package pifo_mon_pkg;

  localparam int ERR_CNT_W = 16;
  localparam int POP_CNT_W = 32;

  // One bit per independent check; kept together so they can be set/cleared as a group.
  typedef struct packed {
    logic vld;
    logic order;
    logic sum;
  } err_flags_t;

  // Reduce a flag group to a single "something went wrong" bit.
  function automatic logic any_err(input err_flags_t f);
    return f.vld | f.order | f.sum;
  endfunction

endpackage

// File: rtl/pifo_mon_delay.sv
// Parameterised 1-bit shift register; dout is the input delayed by DEPTH cycles,
// any reports whether any stage currently holds a one.
module pifo_mon_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic any
);

  logic [DEPTH-1:0] stages;

  // Shift the expectation bit one stage per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];
  assign any  = |stages;

endmodule

// File: rtl/pifo_monitor.sv
// Passive pop-side monitor/scoreboard for a PIFO: occupancy model, pop-valid timing,
// min-priority-first ordering and (optionally) an XOR data checksum.
// Optional feature: define PIFO_MON_CHECKSUM_EN to build the checksum check;
// without it err_sum is tied to 0.
module pifo_monitor
  import pifo_mon_pkg::*;
#(
  parameter  int NUMPIFO = 128,
  parameter  int BITPRIO = 8,
  parameter  int BITDATA = 7,
  parameter  int POP_LAT = 1,
  localparam int BITOCC  = $clog2(NUMPIFO + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_1,
  input  logic [BITPRIO-1:0]   upri_1,
  input  logic [BITDATA-1:0]   udin_1,
  input  logic                 pop_0,
  input  logic                 ovld_0,
  input  logic [BITPRIO-1:0]   opri_0,
  input  logic [BITDATA-1:0]   odout_0,
  input  logic                 clr,
  output logic [BITOCC-1:0]    occ,
  output logic [POP_CNT_W-1:0] pop_cnt,
  output logic                 err_vld,
  output logic                 err_order,
  output logic                 err_sum,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 mon_out
);

  localparam logic [BITOCC-1:0]    OCC_FULL = BITOCC'(NUMPIFO);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  logic               acc_push;
  logic               exp_pop;
  logic               full_swap;
  logic               exp_vld;
  logic               dl_any;
  logic               sum_bad;
  logic [BITPRIO-1:0] last_pri;
  logic               last_ok;
  err_flags_t         cond;
  err_flags_t         flags;

  // Expected ovld_0 stream: each expected pop reappears POP_LAT cycles later.
  pifo_mon_delay #(.DEPTH(POP_LAT)) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (exp_pop),
    .dout (exp_vld),
    .any  (dl_any)
  );

  // Per-cycle push/pop qualification and error conditions.
  always_comb begin
    acc_push   = push_1 && (occ < OCC_FULL);
    exp_pop    = pop_0 && (occ != '0);
    // Push and pop together at full: the element count is left unchanged.
    full_swap  = exp_pop && push_1 && !acc_push;
    cond.vld   = (exp_vld != ovld_0);
    cond.order = ovld_0 && last_ok && (opri_0 < last_pri);
    cond.sum   = sum_bad;
  end

`ifdef PIFO_MON_CHECKSUM_EN
  logic [BITDATA-1:0] sum;
  logic               dirty;
  logic               sum_chk;
  logic [BITDATA-1:0] sum_next;
  logic               dirty_next;

  // The checksum is evaluated (and restarted) once the PIFO is fully drained.
  always_comb begin
    sum_chk    = (occ == '0) && !dl_any && dirty;
    sum_bad    = sum_chk && (sum != '0);
    sum_next   = sum_chk ? '0 : sum;
    sum_next   = sum_next ^ (acc_push ? udin_1 : '0) ^ (ovld_0 ? odout_0 : '0);
    dirty_next = (sum_chk ? 1'b0 : dirty) | acc_push;
  end

  // Checksum accumulator and "data pushed since last check" marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      dirty <= 1'b0;
    end else begin
      sum   <= sum_next;
      dirty <= dirty_next;
    end
  end
`else
  logic unused_data;
  assign unused_data = ^{udin_1, odout_0};
  assign sum_bad     = 1'b0;
`endif

  // Occupancy model.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (full_swap) begin
      occ <= occ;
    end else begin
      occ <= occ + BITOCC'(acc_push) - BITOCC'(exp_pop);
    end
  end

  // Ordering history: any accepted push restarts the monotonic-drain run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pri <= '0;
      last_ok  <= 1'b0;
    end else begin
      if (ovld_0) begin
        last_pri <= opri_0;
      end
      if (acc_push) begin
        last_ok <= 1'b0;
      end else if (ovld_0) begin
        last_ok <= 1'b1;
      end
    end
  end

  // Sticky flags and counters; clr takes precedence over any same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags   <= '0;
      err_cnt <= '0;
      pop_cnt <= '0;
    end else if (clr) begin
      flags   <= '0;
      err_cnt <= '0;
      pop_cnt <= '0;
    end else begin
      flags <= flags | cond;
      if (any_err(cond) && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (ovld_0) begin
        pop_cnt <= pop_cnt + 32'd1;
      end
    end
  end

  // Summary bit, one cycle behind the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_out <= 1'b0;
    end else begin
      mon_out <= any_err(flags);
    end
  end

  assign err_vld   = flags.vld;
  assign err_order = flags.order;
  assign err_sum   = flags.sum;

endmodule

// File: tb/tb_pifo_monitor.sv
// Self-checking bench for pifo_monitor: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_pifo_monitor;

  localparam int NUMPIFO = 128;
  localparam int BITPRIO = 8;
  localparam int BITDATA = 7;
  localparam int POP_LAT = 1;
  localparam int BITOCC  = $clog2(NUMPIFO + 1);

  logic               clk;
  logic               rst_n;
  logic               push_1;
  logic [BITPRIO-1:0] upri_1;
  logic [BITDATA-1:0] udin_1;
  logic               pop_0;
  logic               ovld_0;
  logic [BITPRIO-1:0] opri_0;
  logic [BITDATA-1:0] odout_0;
  logic               clr;
  logic [BITOCC-1:0]  occ;
  logic [31:0]        pop_cnt;
  logic               err_vld;
  logic               err_order;
  logic               err_sum;
  logic [15:0]        err_cnt;
  logic               mon_out;

  pifo_monitor #(
    .NUMPIFO(NUMPIFO), .BITPRIO(BITPRIO), .BITDATA(BITDATA), .POP_LAT(POP_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push_1(push_1), .upri_1(upri_1), .udin_1(udin_1),
    .pop_0(pop_0), .ovld_0(ovld_0), .opri_0(opri_0), .odout_0(odout_0), .clr(clr),
    .occ(occ), .pop_cnt(pop_cnt), .err_vld(err_vld), .err_order(err_order),
    .err_sum(err_sum), .err_cnt(err_cnt), .mon_out(mon_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus-side PIFO: unordered store, min priority extracted on pop.
  typedef struct { int pri; int dat; } elem_t;
  typedef struct { bit vld; int pri; int dat; } resp_t;
  elem_t pq[$];
  resp_t rq[$];
  int    pop_log[$];

  // Reference monitor state.
  int          m_occ;
  int unsigned m_pop_cnt;
  int          m_err_cnt;
  bit          m_vld, m_order, m_sum, m_mon;
  int          m_last_pri;
  bit          m_last_ok;
  int          m_sumv;
  bit          m_dirty;
  bit          m_dl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_occ = 0; m_pop_cnt = 0; m_err_cnt = 0;
    m_vld = 0; m_order = 0; m_sum = 0; m_mon = 0;
    m_last_pri = 0; m_last_ok = 0; m_sumv = 0; m_dirty = 0;
    m_dl = {};
    pq = {};
    rq = {};
    for (int i = 0; i < POP_LAT; i++) begin
      resp_t e;
      e.vld = 0; e.pri = 0; e.dat = 0;
      m_dl.push_back(1'b0);
      rq.push_back(e);
    end
  endfunction

  // Apply the monitor's rules to one cycle of observed inputs.
  function automatic void model_cycle(input bit push, input int pri, input int din,
                                      input bit pop, input bit ov, input int op,
                                      input int od, input bit cl);
    bit acc, ep, expv, busy, cv, co, cs, drained;
    acc  = push && (m_occ < NUMPIFO);
    ep   = pop && (m_occ != 0);
    expv = m_dl[0];
    busy = 0;
    foreach (m_dl[i]) busy |= m_dl[i];
    cv = (expv != ov);
    co = ov && m_last_ok && (op < m_last_pri);
    cs = 0;
    drained = 0;
`ifdef PIFO_MON_CHECKSUM_EN
    drained = (m_occ == 0) && !busy && m_dirty;
    cs = drained && (m_sumv != 0);
`endif
    m_mon = m_vld | m_order | m_sum;
    if (cl) begin
      m_vld = 0; m_order = 0; m_sum = 0; m_err_cnt = 0; m_pop_cnt = 0;
    end else begin
      m_vld |= cv; m_order |= co; m_sum |= cs;
      if ((cv | co | cs) && m_err_cnt < 65535) m_err_cnt++;
      if (ov) m_pop_cnt++;
    end
    if (ov) m_last_pri = op;
    if (acc) m_last_ok = 0;
    else if (ov) m_last_ok = 1;
    if (drained) begin
      m_sumv = 0; m_dirty = 0;
    end
    if (acc) begin
      m_sumv ^= din; m_dirty = 1;
    end
    if (ov) m_sumv ^= od;
    if (!(ep && push && !acc)) m_occ = m_occ + int'(acc) - int'(ep);
    void'(m_dl.pop_front());
    m_dl.push_back(ep);
  endfunction

  // Drive one cycle of raw inputs, advance the model, compare after the edge.
  task automatic step(input bit push, input int pri, input int din, input bit pop,
                      input bit ov, input int op, input int od, input bit cl);
    push_1 = push; upri_1 = BITPRIO'(pri); udin_1 = BITDATA'(din);
    pop_0 = pop; ovld_0 = ov; opri_0 = BITPRIO'(op); odout_0 = BITDATA'(od); clr = cl;
    model_cycle(push, pri, din, pop, ov, op, od, cl);
    @(negedge clk);
    chk("occ", occ, m_occ);
    chk("pop_cnt", pop_cnt, m_pop_cnt);
    chk("err_vld", err_vld, m_vld);
    chk("err_order", err_order, m_order);
    chk("err_sum", err_sum, m_sum);
    chk("err_cnt", err_cnt, m_err_cnt);
    chk("mon_out", mon_out, m_mon);
  endtask

  task automatic idle_m();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle with the bench PIFO answering pops; fault: 1 drop, 2 spurious, 3 data, 4 prio.
  task automatic auto_step(input bit push, input int pri, input int dat, input bit pop,
                           input bit cl, input int fault);
    resp_t cur, nr;
    bit full;
    int mi;
    cur = rq.pop_front();
    full = (pq.size() >= NUMPIFO);
    nr.vld = 0; nr.pri = 0; nr.dat = 0;
    if (pop && pq.size() > 0) begin
      mi = 0;
      for (int i = 1; i < pq.size(); i++) if (pq[i].pri < pq[mi].pri) mi = i;
      nr.vld = 1; nr.pri = pq[mi].pri; nr.dat = pq[mi].dat;
      pq.delete(mi);
      if (push) begin
        elem_t e; e.pri = pri; e.dat = dat; pq.push_back(e);
      end
    end else if (push && !full) begin
      elem_t e; e.pri = pri; e.dat = dat; pq.push_back(e);
    end
    rq.push_back(nr);
    if (cur.vld) pop_log.push_back(cur.pri);
    else begin
      cur.pri = $urandom_range(255); cur.dat = $urandom_range(127);
    end
    case (fault)
      1: cur.vld = 0;
      2: cur.vld = 1;
      3: cur.dat = cur.dat ^ 1;
      4: cur.pri = 0;
      default: ;
    endcase
    step(push, pri, dat, pop, cur.vld, cur.pri, cur.dat, cl);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    #1;
    chk("rst_occ", occ, 0);
    chk("rst_pop_cnt", pop_cnt, 0);
    chk("rst_flags", {err_vld, err_order, err_sum}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_mon_out", mon_out, 0);
    push_1 = 0; pop_0 = 0; ovld_0 = 0; clr = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int push_pct, pop_pct, r;
    rst_n = 0; push_1 = 0; upri_1 = 0; udin_1 = 0; pop_0 = 0;
    ovld_0 = 0; opri_0 = 0; odout_0 = 0; clr = 0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Ordered drain through the bench PIFO.
    auto_step(1, 5, 1, 0, 0, 0);
    auto_step(1, 2, 2, 0, 0, 0);
    auto_step(1, 9, 3, 0, 0, 0);
    repeat (3) auto_step(0, 0, 0, 1, 0, 0);
    auto_step(0, 0, 0, 0, 0, 0);
    chk("drain_len", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      chk("drain_p0", pop_log[0], 2);
      chk("drain_p1", pop_log[1], 5);
      chk("drain_p2", pop_log[2], 9);
    end
    chk("drain_pop_cnt", pop_cnt, 3);
    chk("drain_occ", occ, 0);
    chk("drain_flags", {err_vld, err_order, err_sum, mon_out}, 0);

    // Pop on empty with a forced result valid.
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 200, 0, 0);
    chk("empty_err_vld", err_vld, 1);
    chk("empty_err_cnt", err_cnt, 1);
    chk("empty_mon_early", mon_out, 0);
    idle_m();
    chk("empty_mon_out", mon_out, 1);
    apply_reset();

    // Out-of-order drain without intervening push.
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 2, 2, 0);
    step(0, 0, 0, 0, 1, 1, 1, 0);
    idle_m();
    chk("order_err", err_order, 1);
    chk("order_vld_ok", err_vld, 0);
    apply_reset();

    // Same, but a push between the pops restarts the run.
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 2, 0);
    step(1, 3, 3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 0);
    idle_m();
    chk("order_restart", err_order, 0);
    chk("order_restart_vld", err_vld, 0);
    apply_reset();

    // Data corruption through the checksum.
    step(1, 0, 4, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 4, 0);
    step(0, 0, 0, 0, 1, 1, 6, 0);
    idle_m();
    idle_m();
    chk("sum_occ", occ, 0);
`ifdef PIFO_MON_CHECKSUM_EN
    chk("sum_err", err_sum, 1);
`else
    chk("sum_err", err_sum, 0);
`endif
    apply_reset();

    // Fill past capacity, then push and pop together at full.
    repeat (129) auto_step(1, $urandom_range(255), $urandom_range(127), 0, 0, 0);
    chk("full_occ", occ, 128);
    auto_step(1, 7, 7, 1, 0, 0);
    chk("full_swap_occ", occ, 128);
    auto_step(0, 0, 0, 0, 0, 0);
    chk("full_swap_flags", {err_vld, err_order, err_sum}, 0);
    chk("full_swap_err_cnt", err_cnt, 0);
    apply_reset();

    // Clear in the same cycle as an error, then reset mid-drain.
    repeat (3) auto_step(1, $urandom_range(255), $urandom_range(127), 0, 0, 0);
    auto_step(0, 0, 0, 0, 1, 2);
    chk("clr_flags", {err_vld, err_order, err_sum}, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_pop_cnt", pop_cnt, 0);
    repeat (2) auto_step(0, 0, 0, 1, 0, 0);
    chk("middrain_pop_cnt", pop_cnt, 1);
    apply_reset();

    // Randomized traffic with occasional faults, clears and resets.
    push_pct = 50; pop_pct = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit p, q, c;
      int f;
      if (cyc % 200 == 0) begin
        push_pct = $urandom_range(90, 10);
        pop_pct  = $urandom_range(90, 10);
      end
      p = ($urandom_range(99) < push_pct);
      q = ($urandom_range(99) < pop_pct);
      if (q && pq.size() >= NUMPIFO) p = 0;
      c = ($urandom_range(99) == 0);
      r = $urandom_range(63);
      f = (r < 4) ? r + 1 : 0;
      if ($urandom_range(1499) == 0) apply_reset();
      else auto_step(p, $urandom_range(255), $urandom_range(127), q, c, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pifo_monitor.md
# pifo_monitor

Pop-side monitor and scoreboard for the `pifo` block, sitting on the opposite end of its push/pop interface from the stimulus generator. It passively observes the push stream and the pop request/response stream. It tracks occupancy and checks three things: pop-valid timing against expected occupancy, minimum-priority-first ordering during drains, and data integrity through an XOR checksum. Results are exposed as sticky flags and counters, so the check can run in hardware regressions as well as in simulation.

## Interface
Parameters:
- `NUMPIFO`, 128, PIFO capacity in elements.
- `BITPRIO`, 8, priority width.
- `BITDATA`, 7, data width.
- `POP_LAT`, 1, cycles from `pop_0` to `ovld_0`/`opri_0`/`odout_0`; must be ≥ 1.
- `BITOCC`, `$clog2(NUMPIFO+1)`, occupancy width; derived, not overridden.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `push_1` in 1: observed push request.
- `upri_1` in BITPRIO: observed push priority.
- `udin_1` in BITDATA: observed push data.
- `pop_0` in 1: observed pop request.
- `ovld_0` in 1: observed pop-result valid.
- `opri_0` in BITPRIO: observed popped priority.
- `odout_0` in BITDATA: observed popped data.
- `clr` in 1: synchronous clear of counters and sticky flags.
- `occ` out BITOCC: modelled occupancy.
- `pop_cnt` out 32: valid pops seen; wraps modulo 2^32.
- `err_vld` out 1: sticky; `ovld_0` did not match the expected value.
- `err_order` out 1: sticky; priority ordering violation.
- `err_sum` out 1: sticky; checksum mismatch.
- `err_cnt` out 16: number of cycles with at least one error; saturates at 0xFFFF.
- `mon_out` out 1: registered OR of the three sticky flags.

## Operation
- Accepted push: `acc_push = push_1 && occ < NUMPIFO`. A push at full is ignored and is not an error.
- Expected pop: `exp_pop = pop_0 && occ != 0`, evaluated on the registered `occ`. A same-cycle push does not make an empty PIFO poppable.
- Occupancy: `occ <= occ + acc_push - exp_pop`. When the PIFO is full, a simultaneous push and pop leaves `occ` at NUMPIFO and the push is not accepted.
- Valid check: `exp_pop` enters a POP_LAT-deep delay line. Each cycle, the delay-line output is compared with `ovld_0`; any mismatch sets `err_vld`.
- Order check, using registers `last_pri` and `last_ok`:
  - Any `acc_push` clears `last_ok`.
  - On `ovld_0`, if `last_ok` is set and `opri_0 < last_pri`, set `err_order`.
  - Then `last_pri <= opri_0` and `last_ok <= 1`.
  - A push in the same cycle as `ovld_0` takes priority and clears `last_ok`.
- `pop_cnt` increments on every `ovld_0`.
- `err_cnt` increments by 1 in any cycle that sets at least one flag condition, even if the flag is already set.
- `clr` zeroes `pop_cnt`, `err_cnt` and all sticky flags, and wins over same-cycle increments and sets. It does not touch `occ`, the delay line, `last_*` or checksum state.

## Timing
- All outputs reset to 0 asynchronously. `last_ok`, the delay line and the checksum also reset to 0.
- `occ`, the flags and the counters update on the clock edge after the causing inputs.
- `mon_out` lags the flags by one cycle.
- Reset asserted mid-drain discards all in-flight expectations. After release, the monitor treats the PIFO as empty.

## Configuration
- `PIFO_MON_CHECKSUM_EN` defined:
  - `sum ^= udin_1` on `acc_push`; `sum ^= odout_0` on `ovld_0`.
  - A `dirty` bit is set on `acc_push`.
  - In a cycle where `occ == 0`, the delay line holds no ones, and `dirty` is set: check the checksum. If `sum != 0`, set `err_sum`. In either case, clear `sum` and `dirty`.
- Undefined: no checksum logic is built and `err_sum` is tied to 0.

## Structure
- Package `pifo_mon_pkg` holds:
  - the `err_flags_t` packed struct (vld, order, sum);
  - `ERR_CNT_W = 16`;
  - `POP_CNT_W = 32`.
- Sub-module `pifo_mon_delay`: a parameterised 1-bit shift register of depth POP_LAT. Its outputs are `dout` and `any`, where `any` is the OR of all stages.

## Test plan
- Push (pri 5, data 1), (2, 2), (9, 3), then pop 3 times with the PIFO model at POP_LAT=1: outputs are pri 2, 5, 9. Expect no flags, `pop_cnt`=3, `occ`=0.
- Pop when empty with `ovld_0` forced to 1 one cycle later: `err_vld`=1 and `err_cnt`=1 next cycle, and `mon_out`=1 the cycle after that.
- Pop two elements without intervening pushes, returning pri 2 then 1: `err_order`=1. Repeat with a push between the two pops: no error.
- With the macro defined, push data 4 and 5, then pop returning data 4 and 6: `err_sum`=1 once `occ` and the delay line are empty. Without the macro, `err_sum` stays 0.
- Push 129 times: `occ`=128. Then push and pop simultaneously: `occ` stays 128 and no error is flagged.
- Assert `clr` in the same cycle as an error: flags and `err_cnt` read 0. Assert `rst_n` low mid-drain: all outputs are 0 immediately.
